mem_refill_arbiter: RTL and testbench
=====================================

Name: mem_refill_arbiter

Overview:
Shares the single main-memory port between the instruction cache (line refills) and the data cache (line refills and dirty-line write-backs). It sits below the IF and MEM stages. The cache miss lines into the stall unit stay asserted until this block returns the final beat. Transfers are whole-line bursts of LINE_WORDS beats, issued as one word request per beat. The block keeps the data cache from starving the instruction cache.

Parameters:
ADDR_W, 32, word-address width
DATA_W, 32, data word width
LINE_WORDS, 4, beats per cache line; power of two, >= 2

Ports:
i_Clk  in  1  clock, rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_ICache_Req  in  1  I-cache line refill request, held until o_ICache_Done
i_ICache_Addr  in  ADDR_W  I-cache miss word address
o_ICache_Data  out  DATA_W  refill word
o_ICache_Valid  out  1  o_ICache_Data valid this cycle
o_ICache_Done  out  1  one-cycle pulse, line complete
i_DCache_Req  in  1  D-cache request, held until o_DCache_Done
i_DCache_We  in  1  1 = write-back, 0 = refill; stable while Req is high
i_DCache_Addr  in  ADDR_W  D-cache line word address
i_DCache_WData  in  DATA_W  current write-back beat
o_DCache_WReady  out  1  current write beat consumed; the cache advances to the next word
o_DCache_Data  out  DATA_W  refill word
o_DCache_Valid  out  1  o_DCache_Data valid
o_DCache_Done  out  1  one-cycle pulse, line complete
o_Mem_Req  out  1  beat request
o_Mem_We  out  1  beat is a write
o_Mem_Addr  out  ADDR_W  beat word address
o_Mem_WData  out  DATA_W  write data
i_Mem_Ready  in  1  memory accepts the beat when o_Mem_Req && i_Mem_Ready
i_Mem_RValid  in  1  read data returned, in order
i_Mem_RData  in  DATA_W  read data
o_Busy  out  1  state != IDLE
o_Owner  out  2  00 none, 01 I-cache, 10 D-cache

Behaviour:
- FSM states: IDLE, I_READ, D_READ, D_WRITE, DONE.
- Reset (asynchronous): state IDLE, all counters 0, last_was_d 0, and every output 0.
- IDLE: requests are sampled only in this state.
  - Arbitration when both requests are high: D-cache wins unless last_was_d = 1, in which case I-cache wins. Back-to-back conflicts therefore alternate.
  - A single requester is granted directly.
  - On grant, latch base = Addr with the low log2(LINE_WORDS) bits cleared, latch owner and direction, and clear iss_cnt and rcv_cnt.
  - last_was_d is updated on every grant.
  - Grant takes effect next cycle. First o_Mem_Req appears one cycle after Req is seen in IDLE.
- I_READ / D_READ:
  - o_Mem_Req = (iss_cnt < LINE_WORDS), o_Mem_We = 0, o_Mem_Addr = base | iss_cnt.
  - iss_cnt increments on each accepted beat.
  - Each i_Mem_RValid forwards i_Mem_RData to the owner's Data/Valid in the same cycle (combinational pass-through) and increments rcv_cnt.
  - When the beat with rcv_cnt == LINE_WORDS-1 is received, go to DONE.
  - Accept and return may occur in the same cycle.
- D_WRITE:
  - o_Mem_Req = 1, o_Mem_We = 1, o_Mem_WData = i_DCache_WData, o_Mem_Addr = base | iss_cnt.
  - o_DCache_WReady = i_Mem_Ready in this state.
  - After LINE_WORDS accepted beats, go to DONE. No read response is expected.
- DONE:
  - One-cycle Done pulse to the owner; o_Owner is still valid.
  - Requests are ignored in this cycle, so a stale Req is not re-granted.
  - Next state is IDLE. The requester must drop Req in the cycle after Done.
- Deasserting Req mid-transfer is ignored; the line always completes.
- i_Mem_RValid outside I_READ/D_READ is ignored. Valid outputs are never asserted for the non-owner.
- Counters are log2(LINE_WORDS)+1 bits wide. Address beat bits wrap within the line and never carry into the upper bits.
- Minimum spacing between grants is 1 idle cycle plus 1 DONE cycle.
- Reset mid-transfer aborts immediately. The memory is reset on the same signal, so no late responses are expected.

Decomposition:
- Shared package:
  - state encoding constants (IDLE = 0, I_READ = 1, D_READ = 2, D_WRITE = 3, DONE = 4);
  - owner codes (OWN_NONE, OWN_I, OWN_D);
  - the LINE_WORDS log2 constant used by the caches.
- Sub-module: beat_counter (issue/receive counter with terminal-count flag), instantiated twice.

Test Plan:
- I-only refill: i_ICache_Req at Addr 0x107, memory ready every cycle, RData returned 2 cycles after each accept -> Mem_Addr 0x104, 0x105, 0x106, 0x107; four o_ICache_Valid pulses; Done one cycle after the 4th beat; o_Owner 01 throughout.
- Simultaneous requests after reset: I refill 0x200 and D refill 0x300 -> D served first (0x300..0x303); then I granted (0x200..0x203) even though D re-requests 0x310 during I's transfer.
- D write-back of 0x40, data A0..A3, i_Mem_Ready toggling 1010... -> o_Mem_We = 1; WReady pulses only when Ready = 1; memory sees A0..A3 at 0x40..0x43; o_DCache_Done after 4th acceptance; o_ICache_Valid never asserted.
- Memory backpressure: Ready low for 5 cycles mid-read -> o_Mem_Req stays high; Addr stable; iss_cnt frozen; completion delayed by exactly 5 cycles.
- Reset asserted after 2 of 4 read beats -> all outputs 0 asynchronously, state IDLE. After release, a new I request at 0x80 starts at 0x80 with counters 0.
- Stale request: requester keeps Req high during the DONE cycle and drops it next cycle -> no second grant, o_Busy = 0.

Source files
------------

// File: rtl/mem_refill_arbiter_pkg.sv
// Shared definitions for the memory refill arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : memory-port owner codes, driven on o_Owner
//   LINE_LOG2   : beat-index width for the default line size, used by the caches
//   beat_bits() : beat-index width for an arbitrary power-of-two line size
package mem_refill_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_READ  = 3'd1,
    D_READ  = 3'd2,
    D_WRITE = 3'd3,
    DONE    = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned LINE_LOG2      = $clog2(LINE_WORDS_DEF);

  function automatic int unsigned beat_bits(input int unsigned words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/mem_refill_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, main memory and the refill arbiter.
//   slave  : arbiter view (cache/memory requests in, grants/data/requests out)
//   master : cache and memory side view
// Signal names follow the arbiter's port list (i_* into the arbiter, o_* out).
interface mem_refill_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              i_ICache_Req;
  logic [ADDR_W-1:0] i_ICache_Addr;
  logic [DATA_W-1:0] o_ICache_Data;
  logic              o_ICache_Valid;
  logic              o_ICache_Done;

  logic              i_DCache_Req;
  logic              i_DCache_We;
  logic [ADDR_W-1:0] i_DCache_Addr;
  logic [DATA_W-1:0] i_DCache_WData;
  logic              o_DCache_WReady;
  logic [DATA_W-1:0] o_DCache_Data;
  logic              o_DCache_Valid;
  logic              o_DCache_Done;

  logic              o_Mem_Req;
  logic              o_Mem_We;
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic [DATA_W-1:0] o_Mem_WData;
  logic              i_Mem_Ready;
  logic              i_Mem_RValid;
  logic [DATA_W-1:0] i_Mem_RData;

  logic              o_Busy;
  logic [1:0]        o_Owner;

  modport slave (
    input  i_ICache_Req, i_ICache_Addr,
    input  i_DCache_Req, i_DCache_We, i_DCache_Addr, i_DCache_WData,
    input  i_Mem_Ready, i_Mem_RValid, i_Mem_RData,
    output o_ICache_Data, o_ICache_Valid, o_ICache_Done,
    output o_DCache_WReady, o_DCache_Data, o_DCache_Valid, o_DCache_Done,
    output o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_WData,
    output o_Busy, o_Owner
  );

  modport master (
    output i_ICache_Req, i_ICache_Addr,
    output i_DCache_Req, i_DCache_We, i_DCache_Addr, i_DCache_WData,
    output i_Mem_Ready, i_Mem_RValid, i_Mem_RData,
    input  o_ICache_Data, o_ICache_Valid, o_ICache_Done,
    input  o_DCache_WReady, o_DCache_Data, o_DCache_Valid, o_DCache_Done,
    input  o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_WData,
    input  o_Busy, o_Owner
  );
endinterface

// File: rtl/mem_refill_arbiter_beat_counter.sv
// Beat counter for one line transfer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (has priority over inc_i)
//   inc_i         : count one beat
//   cnt_o         : current count
//   last_o        : count == TERM-1 (the beat being handled is the final one)
//   full_o        : count == TERM (all beats handled)
module mem_refill_arbiter_beat_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned TERM  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             last_o,
  output logic             full_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == WIDTH'(TERM - 1));
  assign full_o = (cnt_q == WIDTH'(TERM));
endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares the single main-memory port between I-cache refills and D-cache
// refills / write-backs, one word request per beat, whole-line bursts.
//   i_Clk, i_Rst_n : clock, asynchronous active-low reset
//   bus            : cache request/response, memory beat and status signals
// Conflicting requests alternate via last_was_d so neither cache starves.
module mem_refill_arbiter
  import mem_refill_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  mem_refill_arbiter_if.slave bus
);
  localparam int unsigned LW = beat_bits(LINE_WORDS);
  localparam int unsigned CW = LW + 1;

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               last_was_d_q, last_was_d_d;
  logic [ADDR_W-1:LW] base_q, base_d;

  logic               cnt_clr, iss_inc, rcv_inc;
  logic [CW-1:0]      iss_cnt, rcv_cnt;
  logic               iss_last, iss_full, rcv_last, rcv_full;
  logic [DATA_W-1:0]  rdata;
  logic [ADDR_W-1:0]  beat_addr;

  assign rdata = bus.i_Mem_RData;
  // Beat index occupies only the low bits, so it can never carry upward.
  assign beat_addr = {base_q, iss_cnt[LW-1:0]};

  mem_refill_arbiter_beat_counter #(.WIDTH(CW), .TERM(LINE_WORDS)) u_iss_cnt (
    .clk_i(i_Clk), .rst_ni(i_Rst_n), .clr_i(cnt_clr), .inc_i(iss_inc),
    .cnt_o(iss_cnt), .last_o(iss_last), .full_o(iss_full)
  );

  mem_refill_arbiter_beat_counter #(.WIDTH(CW), .TERM(LINE_WORDS)) u_rcv_cnt (
    .clk_i(i_Clk), .rst_ni(i_Rst_n), .clr_i(cnt_clr), .inc_i(rcv_inc),
    .cnt_o(rcv_cnt), .last_o(rcv_last), .full_o(rcv_full)
  );

  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    last_was_d_d        = last_was_d_q;
    base_d              = base_q;
    cnt_clr             = 1'b0;
    iss_inc             = 1'b0;
    rcv_inc             = 1'b0;
    bus.o_ICache_Data   = '0;
    bus.o_ICache_Valid  = 1'b0;
    bus.o_ICache_Done   = 1'b0;
    bus.o_DCache_WReady = 1'b0;
    bus.o_DCache_Data   = '0;
    bus.o_DCache_Valid  = 1'b0;
    bus.o_DCache_Done   = 1'b0;
    bus.o_Mem_Req       = 1'b0;
    bus.o_Mem_We        = 1'b0;
    bus.o_Mem_Addr      = '0;
    bus.o_Mem_WData     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_DCache_Req && (!bus.i_ICache_Req || !last_was_d_q)) begin
          owner_d      = OWN_D;
          last_was_d_d = 1'b1;
          base_d       = bus.i_DCache_Addr[ADDR_W-1:LW];
          cnt_clr      = 1'b1;
          state_d      = bus.i_DCache_We ? D_WRITE : D_READ;
        end else if (bus.i_ICache_Req) begin
          owner_d      = OWN_I;
          last_was_d_d = 1'b0;
          base_d       = bus.i_ICache_Addr[ADDR_W-1:LW];
          cnt_clr      = 1'b1;
          state_d      = I_READ;
        end
      end
      I_READ, D_READ: begin
        bus.o_Mem_Req  = !iss_full;
        bus.o_Mem_Addr = beat_addr;
        iss_inc        = !iss_full && bus.i_Mem_Ready;
        if (bus.i_Mem_RValid && !rcv_full) begin
          rcv_inc = 1'b1;
          if (state_q == I_READ) begin
            bus.o_ICache_Data  = rdata;
            bus.o_ICache_Valid = 1'b1;
          end else begin
            bus.o_DCache_Data  = rdata;
            bus.o_DCache_Valid = 1'b1;
          end
          if (rcv_last) begin
            state_d = DONE;
          end
        end
      end
      D_WRITE: begin
        bus.o_Mem_Req       = 1'b1;
        bus.o_Mem_We        = 1'b1;
        bus.o_Mem_Addr      = beat_addr;
        bus.o_Mem_WData     = bus.i_DCache_WData;
        bus.o_DCache_WReady = bus.i_Mem_Ready;
        iss_inc             = bus.i_Mem_Ready;
        if (bus.i_Mem_Ready && iss_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Requests are not looked at here, so a Req still high from the
        // finished line cannot be granted a second time.
        bus.o_ICache_Done = (owner_q == OWN_I);
        bus.o_DCache_Done = (owner_q == OWN_D);
        owner_d           = OWN_NONE;
        state_d           = IDLE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      last_was_d_q <= 1'b0;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_was_d_q <= last_was_d_d;
      base_q       <= base_d;
    end
  end

  assign bus.o_Busy  = (state_q != IDLE);
  assign bus.o_Owner = owner_q;
endmodule

// File: tb/tb_mem_refill_arbiter.sv
module tb_mem_refill_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_refill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(4)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_cyc = 0;
  int rdy_mode = 0;
  logic [1:0] exp_owner = 2'b11;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: read data returned 2 cycles after each accepted read beat.
  logic          p1, p2;
  logic [AW-1:0] a1, a2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= 1'b0; p2 <= 1'b0; a1 <= '0; a2 <= '0;
    end else begin
      p1 <= bus.o_Mem_Req && bus.i_Mem_Ready && !bus.o_Mem_We;
      a1 <= bus.o_Mem_Addr;
      p2 <= p1;
      a2 <= a1;
    end
  end
  assign bus.i_Mem_RValid = p2;
  assign bus.i_Mem_RData  = rd_word(a2);

  // Event log, sampled mid-cycle.
  logic [AW-1:0] acc_addr[$];
  logic [DW-1:0] acc_wd[$];
  logic [AW-1:0] stall_addr[$];
  logic [DW-1:0] ival[$];
  logic [DW-1:0] dval[$];
  int acc_we_n, acc_cyc_last, first_req_cyc, ival_cyc_last;
  int idone_cyc, ddone_cyc, idone_n, ddone_n, own_bad, wr_bad, wr_n;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_Mem_Req && bus.i_Mem_Ready) begin
        acc_addr.push_back(bus.o_Mem_Addr);
        acc_wd.push_back(bus.o_Mem_WData);
        if (bus.o_Mem_We) acc_we_n++;
        acc_cyc_last = cyc;
      end
      if (bus.o_Mem_Req && !bus.i_Mem_Ready) stall_addr.push_back(bus.o_Mem_Addr);
      if (bus.o_Mem_Req && first_req_cyc < 0) first_req_cyc = cyc;
      if (bus.o_ICache_Valid) begin
        ival.push_back(bus.o_ICache_Data);
        ival_cyc_last = cyc;
        if (bus.o_Owner != 2'b01 || bus.o_DCache_Valid) own_bad++;
      end
      if (bus.o_DCache_Valid) begin
        dval.push_back(bus.o_DCache_Data);
        if (bus.o_Owner != 2'b10) own_bad++;
      end
      if (bus.o_ICache_Done) begin idone_n++; idone_cyc = cyc; end
      if (bus.o_DCache_Done) begin ddone_n++; ddone_cyc = cyc; end
      if (bus.o_DCache_WReady) wr_n++;
      if (bus.o_DCache_WReady && !bus.i_Mem_Ready) wr_bad++;
      if (exp_owner != 2'b11 && bus.o_Busy && bus.o_Owner != exp_owner) own_bad++;
    end
  end

  task automatic clr_log();
    acc_addr.delete(); acc_wd.delete(); stall_addr.delete();
    ival.delete(); dval.delete();
    acc_we_n = 0; acc_cyc_last = -1; first_req_cyc = -1; ival_cyc_last = -1;
    idone_cyc = -1; ddone_cyc = -1; idone_n = 0; ddone_n = 0;
    own_bad = 0; wr_bad = 0; wr_n = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic start_req(input bit is_d, input bit we, input logic [AW-1:0] addr);
    @(posedge clk); #1;
    if (is_d) begin
      bus.i_DCache_Req = 1'b1; bus.i_DCache_We = we;
      bus.i_DCache_Addr = addr; bus.i_DCache_WData = 32'hA0;
    end else begin
      bus.i_ICache_Req = 1'b1; bus.i_ICache_Addr = addr;
    end
    req_cyc = cyc;
  endtask

  // Plays the requesting cache until its Done, then drops Req the next cycle.
  task automatic run_until_done(input bit is_d, output bit ok);
    int widx = 0;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       bus.i_Mem_Ready = ((cyc - req_cyc) % 2) == 1;
        2:       bus.i_Mem_Ready = !((cyc - req_cyc) >= 3 && (cyc - req_cyc) <= 7);
        default: bus.i_Mem_Ready = 1'b1;
      endcase
      bus.i_DCache_WData = 32'hA0 + widx;
      @(negedge clk);
      if (bus.o_DCache_WReady) widx++;
      if (is_d ? bus.o_DCache_Done : bus.o_ICache_Done) ok = 1'b1;
    end
    @(posedge clk); #1;
    if (is_d) bus.i_DCache_Req = 1'b0; else bus.i_ICache_Req = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] ctl;
    rst_n = 1'b0;
    bus.i_ICache_Req = 0; bus.i_ICache_Addr = '0;
    bus.i_DCache_Req = 0; bus.i_DCache_We = 0; bus.i_DCache_Addr = '0;
    bus.i_DCache_WData = '0; bus.i_Mem_Ready = 1'b1;
    #12;
    ctl = {bus.o_Busy, bus.o_Owner, bus.o_Mem_Req, bus.o_Mem_We, bus.o_ICache_Valid,
           bus.o_ICache_Done, bus.o_DCache_Valid, bus.o_DCache_Done, bus.o_DCache_WReady};
    total++;
    if (ctl !== 10'b0) begin bad++; $display("FAIL reset_ctl: got %b want 0", ctl); end
    total++;
    if (bus.o_Mem_Addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.o_Mem_Addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_line(input string nm, input logic [AW-1:0] base, input int off);
    // off selects the first of four consecutive logged accepts
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] got;
      got = (off + k < acc_addr.size()) ? acc_addr[off + k] : 'x;
      total++;
      if (got !== base + AW'(k)) begin
        bad++; $display("FAIL %s_addr%0d: got %h want %h", nm, k, got, base + AW'(k));
      end
    end
  endtask

  task automatic test_i_refill();
    bit ok;
    clr_log(); exp_owner = 2'b01; rdy_mode = 0;
    start_req(0, 0, 32'h107);
    run_until_done(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL i_done_timeout: got 0 want 1"); end
    total++; if (first_req_cyc !== req_cyc + 1) begin bad++;
      $display("FAIL i_first_req: got %0d want %0d", first_req_cyc - req_cyc, 1); end
    total++; if (acc_addr.size() !== 4) begin bad++;
      $display("FAIL i_beats: got %0d want 4", acc_addr.size()); end
    check_line("i", 32'h104, 0);
    total++; if (ival.size() !== 4) begin bad++;
      $display("FAIL i_valid_cnt: got %0d want 4", ival.size()); end
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] got;
      got = (k < ival.size()) ? ival[k] : 'x;
      total++;
      if (got !== rd_word(32'h104 + k)) begin bad++;
        $display("FAIL i_data%0d: got %h want %h", k, got, rd_word(32'h104 + k)); end
    end
    total++; if (idone_cyc !== req_cyc + 7) begin bad++;
      $display("FAIL i_done_cyc: got %0d want %0d", idone_cyc - req_cyc, 7); end
    total++; if (idone_cyc !== ival_cyc_last + 1) begin bad++;
      $display("FAIL i_done_after_beat: got %0d want %0d", idone_cyc, ival_cyc_last + 1); end
    total++; if (own_bad !== 0 || dval.size() !== 0) begin bad++;
      $display("FAIL i_owner: got %0d/%0d want 0/0", own_bad, dval.size()); end
  endtask

  task automatic test_simultaneous();
    bit ok1, ok2, ok3;
    do_reset();
    clr_log(); exp_owner = 2'b11; rdy_mode = 0;
    @(posedge clk); #1;
    bus.i_ICache_Req = 1; bus.i_ICache_Addr = 32'h200;
    bus.i_DCache_Req = 1; bus.i_DCache_We = 0; bus.i_DCache_Addr = 32'h300;
    req_cyc = cyc;
    run_until_done(1, ok1);
    @(posedge clk); #1;
    bus.i_DCache_Req = 1; bus.i_DCache_We = 0; bus.i_DCache_Addr = 32'h310;
    run_until_done(0, ok2);
    run_until_done(1, ok3);
    total++; if (!(ok1 && ok2 && ok3)) begin bad++;
      $display("FAIL sim_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    total++; if (acc_addr.size() !== 12) begin bad++;
      $display("FAIL sim_beats: got %0d want 12", acc_addr.size()); end
    check_line("sim_d", 32'h300, 0);
    check_line("sim_i", 32'h200, 4);
    check_line("sim_d2", 32'h310, 8);
    total++; if (idone_cyc !== req_cyc + 15) begin bad++;
      $display("FAIL sim_i_done: got %0d want 15", idone_cyc - req_cyc); end
    total++; if (ddone_cyc !== req_cyc + 23) begin bad++;
      $display("FAIL sim_d_done: got %0d want 23", ddone_cyc - req_cyc); end
    total++; if (ival.size() !== 4 || dval.size() !== 8 || own_bad !== 0) begin bad++;
      $display("FAIL sim_valids: got i=%0d d=%0d own=%0d want 4 8 0", ival.size(), dval.size(), own_bad); end
    total++; if ((dval.size() > 4 ? dval[4] : 'x) !== rd_word(32'h310)) begin bad++;
      $display("FAIL sim_d2_data: got %h want %h", dval.size() > 4 ? dval[4] : 'x, rd_word(32'h310)); end
  endtask

  task automatic test_writeback();
    bit ok;
    clr_log(); exp_owner = 2'b10; rdy_mode = 1;
    start_req(1, 1, 32'h40);
    run_until_done(1, ok);
    bus.i_DCache_We = 0; rdy_mode = 0;
    total++; if (!ok) begin bad++; $display("FAIL wb_timeout: got 0 want 1"); end
    total++; if (acc_addr.size() !== 4 || acc_we_n !== 4) begin bad++;
      $display("FAIL wb_beats: got %0d/%0d want 4/4", acc_addr.size(), acc_we_n); end
    check_line("wb", 32'h40, 0);
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] got;
      got = (k < acc_wd.size()) ? acc_wd[k] : 'x;
      total++;
      if (got !== 32'hA0 + k) begin bad++;
        $display("FAIL wb_data%0d: got %h want %h", k, got, 32'hA0 + k); end
    end
    total++; if (wr_bad !== 0 || wr_n !== 4) begin bad++;
      $display("FAIL wb_wready: got bad=%0d n=%0d want 0 4", wr_bad, wr_n); end
    total++; if (ddone_cyc !== req_cyc + 8 || ddone_cyc !== acc_cyc_last + 1) begin bad++;
      $display("FAIL wb_done_cyc: got %0d want 8", ddone_cyc - req_cyc); end
    total++; if (ival.size() !== 0 || idone_n !== 0 || own_bad !== 0) begin bad++;
      $display("FAIL wb_icache_quiet: got %0d/%0d/%0d want 0", ival.size(), idone_n, own_bad); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clr_log(); exp_owner = 2'b01; rdy_mode = 2;
    start_req(0, 0, 32'h500);
    run_until_done(0, ok);
    rdy_mode = 0;
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout: got 0 want 1"); end
    total++; if (stall_addr.size() !== 5) begin bad++;
      $display("FAIL bp_stall_cycles: got %0d want 5", stall_addr.size()); end
    foreach (stall_addr[k]) begin
      total++;
      if (stall_addr[k] !== 32'h502) begin bad++;
        $display("FAIL bp_stall_addr%0d: got %h want 00000502", k, stall_addr[k]); end
    end
    check_line("bp", 32'h500, 0);
    total++; if (idone_cyc !== req_cyc + 12) begin bad++;
      $display("FAIL bp_done_cyc: got %0d want 12", idone_cyc - req_cyc); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [9:0] ctl;
    clr_log(); exp_owner = 2'b01; rdy_mode = 0;
    start_req(0, 0, 32'h600);
    for (int k = 0; k < 20 && ival.size() < 2; k++) @(negedge clk);
    total++; if (ival.size() !== 2) begin bad++;
      $display("FAIL rst_pre_beats: got %0d want 2", ival.size()); end
    #2 rst_n = 1'b0;
    #1;
    ctl = {bus.o_Busy, bus.o_Owner, bus.o_Mem_Req, bus.o_Mem_We, bus.o_ICache_Valid,
           bus.o_ICache_Done, bus.o_DCache_Valid, bus.o_DCache_Done, bus.o_DCache_WReady};
    total++; if (ctl !== 10'b0) begin bad++; $display("FAIL rst_mid_ctl: got %b want 0", ctl); end
    total++; if ({bus.o_Mem_Addr, bus.o_ICache_Data} !== '0) begin bad++;
      $display("FAIL rst_mid_data: got %h %h want 0", bus.o_Mem_Addr, bus.o_ICache_Data); end
    bus.i_ICache_Req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_log();
    start_req(0, 0, 32'h80);
    run_until_done(0, ok);
    total++; if (!ok || first_req_cyc !== req_cyc + 1) begin bad++;
      $display("FAIL rst_restart: got ok=%b first=%0d want 1 1", ok, first_req_cyc - req_cyc); end
    check_line("rst", 32'h80, 0);
    total++; if (idone_cyc !== req_cyc + 7) begin bad++;
      $display("FAIL rst_done_cyc: got %0d want 7", idone_cyc - req_cyc); end
  endtask

  task automatic test_stale();
    bit ok;
    clr_log(); exp_owner = 2'b01; rdy_mode = 0;
    start_req(0, 0, 32'h7F3);
    run_until_done(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL stale_timeout: got 0 want 1"); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (bus.o_Busy !== 1'b0 || bus.o_Owner !== 2'b00) begin bad++;
        $display("FAIL stale_idle%0d: got busy=%b owner=%b want 0 00", k, bus.o_Busy, bus.o_Owner); end
    end
    check_line("stale", 32'h7F0, 0);
    total++; if (acc_addr.size() !== 4 || idone_n !== 1) begin bad++;
      $display("FAIL stale_regrant: got beats=%0d dones=%0d want 4 1", acc_addr.size(), idone_n); end
  endtask

  initial begin
    clr_log();
    test_reset();
    test_i_refill();
    test_simultaneous();
    test_writeback();
    test_backpressure();
    test_reset_mid();
    test_stale();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
